display_timing_gen: RTL and testbench

- Parametrised successor to the fixed-count 1024x600 display timing block.
- Generates the full raster, including front porch, sync and back porch, with signed coordinates. Blanking is at negative coordinates; active area is 0..H_RES-1 / 0..V_RES-1.
- Drives real hsync/vsync with configurable polarity, plus active-area start strobes for pixel pipelines.
- Sits between the pixel clock domain and the video output / framebuffer read logic.

---
 rtl/display_timing_gen_if.sv | 37 +++
 rtl/display_timing_gen.sv | 115 +++++++++++
 tb/tb_display_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_timing_gen_if.sv
// Video timing bundle produced by display_timing_gen and read by the
// video output / framebuffer read logic. The frame_cnt member and the FCW
// parameter exist only when DISPLAY_FRAME_CNT_EN is defined.
interface display_timing_gen_if #(
    parameter int CORDW = 12
`ifdef DISPLAY_FRAME_CNT_EN
    ,
    parameter int FCW   = 16
`endif
);
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic                    frame;
    logic                    line;
    logic                    frame_act;
    logic                    line_act;
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
`ifdef DISPLAY_FRAME_CNT_EN
    logic [FCW-1:0]          frame_cnt;
`endif

    modport master (
        output hsync, vsync, de, frame, line, frame_act, line_act, sx, sy
`ifdef DISPLAY_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input hsync, vsync, de, frame, line, frame_act, line_act, sx, sy
`ifdef DISPLAY_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/display_timing_gen.sv
// Parametrised display raster generator in the pixel clock domain.
// Blanking sits at negative signed coordinates; the active area runs from
// (0,0) to (H_RES-1,V_RES-1). Every output is registered from the current
// counter position, so all of them describe the position shown on sx/sy.
// Optional feature macro: DISPLAY_FRAME_CNT_EN (adds the frame_cnt counter).
module display_timing_gen #(
    parameter int CORDW  = 12,
    parameter int H_RES  = 1024,
    parameter int V_RES  = 600,
    parameter int H_FP   = 50,
    parameter int H_SYNC = 105,
    parameter int H_BP   = 144,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 10,
    parameter int V_BP   = 11,
    parameter int H_POL  = 0,
    parameter int V_POL  = 1,
    parameter int FCW    = 16
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix,
    display_timing_gen_if.master vid
);

    // Raster landmarks in signed coordinates.
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
    localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
    localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] ZERO   = '0;
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    // Asserted sync levels.
    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    // The signed coordinate range must cover both blanking and active extents.
    localparam int CMAX = 2 ** (CORDW - 1);
    if ((H_FP + H_SYNC + H_BP) > CMAX || H_RES > CMAX ||
        (V_FP + V_SYNC + V_BP) > CMAX || V_RES > CMAX) begin : g_cordw_check
        $error("display_timing_gen: CORDW too narrow for the raster");
    end
    if (FCW < 1) begin : g_fcw_check
        $error("display_timing_gen: FCW must be at least 1");
    end

    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic signed [CORDW-1:0] x_nxt;
    logic signed [CORDW-1:0] y_nxt;

    // Next raster position: step along the line, wrap to the next line, wrap the frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        x_nxt = x + ONE;
        y_nxt = y;
        if (x == HA_END) begin
            x_nxt = H_STA;
            y_nxt = (y == VA_END) ? V_STA : y + ONE;
        end
    end

    // Raster counter; reset overrides any update and restarts at the raster origin.
    always_ff @(posedge clk_pix) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_pix) begin
            x <= H_STA;
            y <= V_STA;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    // Registered outputs decoded from the current counter position.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            vid.sx        <= H_STA;
            vid.sy        <= V_STA;
            vid.hsync     <= !HS_ON;
            vid.vsync     <= !VS_ON;
            vid.de        <= 1'b0;
            vid.frame     <= 1'b0;
            vid.line      <= 1'b0;
            vid.frame_act <= 1'b0;
            vid.line_act  <= 1'b0;
        end else begin
            vid.sx        <= x;
            vid.sy        <= y;
            vid.hsync     <= (x >= HS_STA && x < HS_END) ? HS_ON : !HS_ON;
            vid.vsync     <= (y >= VS_STA && y < VS_END) ? VS_ON : !VS_ON;
            vid.de        <= (x >= ZERO && y >= ZERO);
            vid.frame     <= (x == H_STA && y == V_STA);
            vid.line      <= (x == H_STA);
            vid.frame_act <= (x == ZERO && y == ZERO);
            vid.line_act  <= (x == ZERO && y >= ZERO);
        end
    end

`ifdef DISPLAY_FRAME_CNT_EN
    // Frame counter: counts registered frame strobes, wrapping modulo 2^FCW.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            vid.frame_cnt <= '0;
        end else if (vid.frame) begin
            vid.frame_cnt <= vid.frame_cnt + FCW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen. Two instances share one pixel
// clock: A uses the default 1024x600 timing, B a tiny raster so that full
// frames, the frame wrap and a mid-frame reset fit in a short run.
// Expected samples are queued with (epoch, cycle) tags; per-instance
// monitors sample on the falling edge, pop matching entries and compare.
module tb_display_timing_gen;

    typedef struct {
        int          epoch;
        int          t;
        int          sx;
        int          sy;
        logic [6:0]  flg;   // {hsync, vsync, de, frame, line, frame_act, line_act}
        int          cnt;   // expected frame_cnt, -1 = not checked
        string       name;
    } exp_t;

    localparam int A_END = 39700;
    localparam int B_RST = 580;

    logic clk_pix = 1'b0;
    logic rst_a   = 1'b1;
    logic rst_b   = 1'b1;
    bit   done_a  = 1'b0;
    bit   done_b  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk_pix = ~clk_pix;

    display_timing_gen_if #(.CORDW(12)
`ifdef DISPLAY_FRAME_CNT_EN
        , .FCW(16)
`endif
    ) vid_a ();

    display_timing_gen_if #(.CORDW(12)
`ifdef DISPLAY_FRAME_CNT_EN
        , .FCW(2)
`endif
    ) vid_b ();

    display_timing_gen #(.CORDW(12)) u_dut_a (
        .clk_pix (clk_pix),
        .rst_pix (rst_a),
        .vid     (vid_a)
    );

    display_timing_gen #(
        .CORDW(12), .H_RES(8), .V_RES(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(0), .FCW(2)
    ) u_dut_b (
        .clk_pix (clk_pix),
        .rst_pix (rst_b),
        .vid     (vid_b)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int ep, input int t, input int sx,
                                input int sy, input logic [6:0] flg, input int cnt);
        exp_t e;
        e.epoch = ep;
        e.t     = t;
        e.sx    = sx;
        e.sy    = sy;
        e.flg   = flg;
        e.cnt   = cnt;
        e.name  = $sformatf("%s_e%0d_t%0d", tag, ep, t);
        return e;
    endfunction

    task automatic cmp_item(input exp_t e, input int sx, input int sy,
                            input logic [6:0] f, input int cnt);
        check({e.name, ".sx"}, sx, e.sx);
        check({e.name, ".sy"}, sy, e.sy);
        check({e.name, ".flags"}, int'(f), int'(e.flg));
        if (e.cnt >= 0 && cnt >= 0) check({e.name, ".cnt"}, cnt, e.cnt);
    endtask

    task automatic drain(inout exp_t q[$], input int ep, input int t, input int sx,
                         input int sy, input logic [6:0] f, input int cnt);
        exp_t e;
        while (q.size() > 0 && (q[0].epoch < ep || (q[0].epoch == ep && q[0].t <= t))) begin
            e = q.pop_front();
            if (e.epoch == ep && e.t == t) begin
                cmp_item(e, sx, sy, f, cnt);
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.missed: sample never seen, now at epoch %0d t %0d", e.name, ep, t);
            end
        end
    endtask

    // ---------------- monitor A ----------------
    logic rst_a_q = 1'b1;
    bit   in_rst_a = 1'b1;
    int   t_a = -1, ep_a = 0;
    int   last_line_a = -1, line_cnt_a = 0, line_bad_a = 0;
    bit   hs_prev_a = 1'b1;
    int   hs_start_a = 0, hs_len_a = 0, hs_runs_a = 0, hs_bad_a = 0;
    int   vs_cnt_a = 0, de_cnt_a = 0, la_cnt_a = 0, la_bad_a = 0;

    always @(posedge clk_pix) rst_a_q <= rst_a;

    always @(negedge clk_pix) begin
        logic [6:0] f;
        int sx, sy, cnt;
        f  = {vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.frame, vid_a.line,
              vid_a.frame_act, vid_a.line_act};
        sx = int'(vid_a.sx);
        sy = int'(vid_a.sy);
`ifdef DISPLAY_FRAME_CNT_EN
        cnt = int'(vid_a.frame_cnt);
`else
        cnt = -1;
`endif
        if (rst_a_q) begin
            check("a_rst.sx", sx, -299);
            check("a_rst.sy", sy, -24);
            check("a_rst.flags", int'(f), int'(7'b1000000));
            if (cnt >= 0) check("a_rst.cnt", cnt, 0);
            in_rst_a = 1'b1;
            t_a = -1;
        end else begin
            if (in_rst_a) begin
                ep_a++;
                in_rst_a = 1'b0;
            end
            t_a++;
            drain(qa, ep_a, t_a, sx, sy, f, cnt);
            if (ep_a == 1 && t_a <= A_END) begin
                if (vid_a.line) begin
                    if (last_line_a >= 0 && t_a - last_line_a != 1323) line_bad_a++;
                    last_line_a = t_a;
                    line_cnt_a++;
                end
                if (!vid_a.hsync) begin
                    if (hs_prev_a) begin
                        hs_start_a = sx;
                        hs_len_a = 0;
                    end
                    hs_len_a++;
                end else if (!hs_prev_a) begin
                    hs_runs_a++;
                    if (hs_len_a != 105 || hs_start_a != -249) hs_bad_a++;
                end
                hs_prev_a = vid_a.hsync;
                if (vid_a.vsync) vs_cnt_a++;
                if (vid_a.de) de_cnt_a++;
                if (vid_a.line_act) begin
                    la_cnt_a++;
                    if (!(sx == 0 && sy >= 0)) la_bad_a++;
                end
            end
        end
    end

    // ---------------- monitor B ----------------
    logic rst_b_q = 1'b1;
    bit   in_rst_b = 1'b1;
    int   t_b = -1, ep_b = 0;
    int   de_cnt_b = 0, vs_cnt_b = 0, ln_cnt_b = 0, fa_cnt_b = 0, fr_cnt_b = 0;

    always @(posedge clk_pix) rst_b_q <= rst_b;

    always @(negedge clk_pix) begin
        logic [6:0] f;
        int sx, sy, cnt;
        f  = {vid_b.hsync, vid_b.vsync, vid_b.de, vid_b.frame, vid_b.line,
              vid_b.frame_act, vid_b.line_act};
        sx = int'(vid_b.sx);
        sy = int'(vid_b.sy);
`ifdef DISPLAY_FRAME_CNT_EN
        cnt = int'(vid_b.frame_cnt);
`else
        cnt = -1;
`endif
        if (rst_b_q) begin
            check($sformatf("b_rst_ep%0d.sx", ep_b), sx, -7);
            check($sformatf("b_rst_ep%0d.sy", ep_b), sy, -4);
            check($sformatf("b_rst_ep%0d.flags", ep_b), int'(f), int'(7'b0100000));
            if (cnt >= 0) check($sformatf("b_rst_ep%0d.cnt", ep_b), cnt, 0);
            in_rst_b = 1'b1;
            t_b = -1;
        end else begin
            if (in_rst_b) begin
                ep_b++;
                in_rst_b = 1'b0;
            end
            t_b++;
            drain(qb, ep_b, t_b, sx, sy, f, cnt);
            if (ep_b == 1 && t_b < 480) begin
                if (vid_b.de) de_cnt_b++;
                if (!vid_b.vsync) vs_cnt_b++;
                if (vid_b.line) ln_cnt_b++;
            end
            if (ep_b == 1 && t_b <= B_RST) begin
                if (vid_b.frame_act) fa_cnt_b++;
                if (vid_b.frame) fr_cnt_b++;
            end
        end
    end

    // ---------------- stimulus A: default timing ----------------
    initial begin
        qa.push_back(mk("a", 1,     0, -299, -24, 7'b1001100, -1));
        qa.push_back(mk("a", 1,     1, -298, -24, 7'b1000000,  1));
        qa.push_back(mk("a", 1,    49, -250, -24, 7'b1000000, -1));
        qa.push_back(mk("a", 1,    50, -249, -24, 7'b0000000, -1));
        qa.push_back(mk("a", 1,   154, -145, -24, 7'b0000000, -1));
        qa.push_back(mk("a", 1,   155, -144, -24, 7'b1000000, -1));
        qa.push_back(mk("a", 1,  1322, 1023, -24, 7'b1000000, -1));
        qa.push_back(mk("a", 1,  1323, -299, -23, 7'b1000100, -1));
        qa.push_back(mk("a", 1,  3968, 1023, -22, 7'b1000000, -1));
        qa.push_back(mk("a", 1,  3969, -299, -21, 7'b1100100, -1));
        qa.push_back(mk("a", 1, 17198, 1023, -12, 7'b1100000, -1));
        qa.push_back(mk("a", 1, 17199, -299, -11, 7'b1000100, -1));
        qa.push_back(mk("a", 1, 32050,   -1,   0, 7'b1000000, -1));
        qa.push_back(mk("a", 1, 32051,    0,   0, 7'b1010011, -1));
        qa.push_back(mk("a", 1, 39689, 1023,   5, 7'b1010000, -1));
        qa.push_back(mk("a", 1, 39690, -299,   6, 7'b1000100, -1));
        repeat (5) @(negedge clk_pix);
        rst_a = 1'b0;
        repeat (A_END + 5) @(negedge clk_pix);
        done_a = 1'b1;
    end

    // ---------------- stimulus B: tiny raster, frame wrap, mid-frame reset ----------------
    initial begin
        qb.push_back(mk("b", 1,   0, -7, -4, 7'b0101100, 0));
        qb.push_back(mk("b", 1,   1, -6, -4, 7'b0100000, 1));
        qb.push_back(mk("b", 1,   2, -5, -4, 7'b1100000, -1));
        qb.push_back(mk("b", 1,   4, -3, -4, 7'b1100000, -1));
        qb.push_back(mk("b", 1,   5, -2, -4, 7'b0100000, -1));
        qb.push_back(mk("b", 1,  15, -7, -3, 7'b0000100, -1));
        qb.push_back(mk("b", 1,  45, -7, -1, 7'b0100100, -1));
        qb.push_back(mk("b", 1,  67,  0,  0, 7'b0110011, -1));
        qb.push_back(mk("b", 1,  68,  1,  0, 7'b0110000, -1));
        qb.push_back(mk("b", 1,  74,  7,  0, 7'b0110000, -1));
        qb.push_back(mk("b", 1,  75, -7,  1, 7'b0100100, -1));
        qb.push_back(mk("b", 1,  82,  0,  1, 7'b0110001, -1));
        qb.push_back(mk("b", 1, 119,  7,  3, 7'b0110000, 1));
        qb.push_back(mk("b", 1, 120, -7, -4, 7'b0101100, 1));
        qb.push_back(mk("b", 1, 121, -6, -4, 7'b0100000, 2));
        qb.push_back(mk("b", 1, 241, -6, -4, 7'b0100000, 3));
        qb.push_back(mk("b", 1, 361, -6, -4, 7'b0100000, 0));
        qb.push_back(mk("b", 1, 481, -6, -4, 7'b0100000, 1));
        qb.push_back(mk("b", 1, 579,  2,  2, 7'b0110000, -1));
        qb.push_back(mk("b", 1, 580,  3,  2, 7'b0110000, 1));
        qb.push_back(mk("b", 2,   0, -7, -4, 7'b0101100, 0));
        qb.push_back(mk("b", 2,   1, -6, -4, 7'b0100000, 1));
        qb.push_back(mk("b", 2,  67,  0,  0, 7'b0110011, -1));
        repeat (5) @(negedge clk_pix);
        rst_b = 1'b0;
        repeat (B_RST + 1) @(negedge clk_pix);
        rst_b = 1'b1;
        repeat (3) @(negedge clk_pix);
        rst_b = 1'b0;
        repeat (75) @(negedge clk_pix);
        done_b = 1'b1;
    end

    // ---------------- end of run: aggregate checks and summary ----------------
    initial begin
        for (int i = 0; i < 60000 && !(done_a && done_b); i++) @(negedge clk_pix);
        check("run_complete", int'(done_a && done_b), 1);
        @(negedge clk_pix);
        check("a_line_count", line_cnt_a, 31);
        check("a_line_gap_errors", line_bad_a, 0);
        check("a_hsync_runs", hs_runs_a, 30);
        check("a_hsync_run_errors", hs_bad_a, 0);
        check("a_vsync_cycles", vs_cnt_a, 10 * 1323);
        check("a_de_cycles", de_cnt_a, 6 * 1024);
        check("a_line_act_count", la_cnt_a, 6);
        check("a_line_act_misplaced", la_bad_a, 0);
        check("b_de_cycles_4frames", de_cnt_b, 4 * 32);
        check("b_vsync_cycles_4frames", vs_cnt_b, 4 * 30);
        check("b_line_count_4frames", ln_cnt_b, 32);
        check("b_frame_act_count", fa_cnt_b, 5);
        check("b_frame_count", fr_cnt_b, 5);
        check("a_queue_left", qa.size(), 0);
        check("b_queue_left", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
